// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes (common db_estado encoding with the TX
// control unit), baud-rate divisors and frame format constants.
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    START    = 4'd2,
    DADOS    = 4'd3,
    STOP     = 4'd4,
    ARMAZENA = 4'd5,
    ERRO     = 4'd6
  } estado_t;

  localparam int CLKS_115200 = 434;
  localparam int CLKS_9600   = 5208;
  localparam int DATA_BITS   = 8;
  localparam int STOP_BITS   = 1;

endpackage

`default_nettype wire

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 so an idle line
// never looks like a start bit coming out of reset.
`default_nettype none
`timescale 1ns/1ps

module sincronizador_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre, holds the last good byte
// until the consumer clears it, and keeps sticky framing/overrun flags.
`default_nettype none
`timescale 1ns/1ps

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_115200,
  parameter int CNT_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       limpa,
  output logic [7:0] dados_ascii,
  output logic       tem_dado,
  output logic       pronto,
  output logic       erro_framing,
  output logic       erro_overrun,
  output logic [3:0] db_estado,
  output logic       db_tick
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

  logic             rx_s;
  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dados_q, dados_d;
  logic             tem_q, tem_d;
  logic             framing_q, framing_d;
  logic             overrun_q, overrun_d;
  logic             tick;
  logic             pronto_w;

  sincronizador_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (entrada_serial),
    .q_o   (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= INICIAL;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      dados_q   <= '0;
      tem_q     <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      dados_q   <= dados_d;
      tem_q     <= tem_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    dados_d   = dados_q;
    tem_d     = tem_q;
    framing_d = framing_q;
    overrun_d = overrun_q;
    tick      = 1'b0;
    pronto_w  = 1'b0;

    // Error flags only clear once the consumer has drained the holding register.
    if (limpa) begin
      tem_d = 1'b0;
      if (!tem_q) begin
        framing_d = 1'b0;
        overrun_d = 1'b0;
      end
    end

    case (state_q)
      INICIAL: state_d = ESPERA;
      ESPERA: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          tick = 1'b1;
          if (rx_s) begin
            state_d = ESPERA;
          end else begin
            state_d = DADOS;
            idx_d   = '0;
          end
        end
      end
      DADOS: begin
        if (cnt_q == BIT_LAST) begin
          tick           = 1'b1;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          tick = 1'b1;
          if (rx_s) begin
            state_d = ARMAZENA;
          end else begin
            framing_d = 1'b1;
            state_d   = ERRO;
          end
        end
      end
      ARMAZENA: begin
        // A limpa in this same cycle counts as having taken the previous byte.
        pronto_w = 1'b1;
        dados_d  = shift_q;
        tem_d    = 1'b1;
        if (tem_q && !limpa) overrun_d = 1'b1;
        state_d  = ESPERA;
      end
      ERRO: begin
        if (rx_s) state_d = ESPERA;
      end
      default: state_d = INICIAL;
    endcase

    cnt_d = (state_d != state_q || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  assign dados_ascii  = dados_q;
  assign tem_dado     = tem_q;
  assign pronto       = pronto_w;
  assign erro_framing = framing_q;
  assign erro_overrun = overrun_q;
  assign db_estado    = 4'(state_q);
  assign db_tick      = tick;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: drives 8N1 frames at 434 clocks/bit and checks
// received bytes, latency, glitch rejection, error flags and reset behaviour.
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CLKS = 434;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic       limpa = 1'b0;
  logic [7:0] dados_ascii;
  logic       tem_dado;
  logic       pronto;
  logic       erro_framing;
  logic       erro_overrun;
  logic [3:0] db_estado;
  logic       db_tick;

  uart_rx #(.CLKS_PER_BIT(CLKS), .CNT_W(13)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .limpa          (limpa),
    .dados_ascii    (dados_ascii),
    .tem_dado       (tem_dado),
    .pronto         (pronto),
    .erro_framing   (erro_framing),
    .erro_overrun   (erro_overrun),
    .db_estado      (db_estado),
    .db_tick        (db_tick)
  );

  always #10 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         pronto_cnt = 0;
  bit         lat_armed = 1'b0;
  bit         saw_start = 1'b0;
  bit         chk_pending = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Byte is registered at the end of the pronto cycle, so compare one cycle later.
  always @(negedge clock) begin
    if (db_estado == 4'd2) saw_start = 1'b1;
    if (chk_pending) begin
      chk_pending = 1'b0;
      check_eq("rx_byte", {24'b0, dados_ascii}, {24'b0, exp_b});
      check_eq("tem_dado_after_load", {31'b0, tem_dado}, 32'd1);
    end
    if (pronto === 1'b1) begin
      pronto_cnt++;
      if (lat_armed) begin
        lat_armed = 1'b0;
        check_eq("pronto_latency_in_window",
                 {31'b0, ((cyc - start_cyc) >= 4124) && ((cyc - start_cyc) <= 4128)}, 32'd1);
      end
      if (sb.size() == 0) begin
        check_eq("pronto_unexpected", {31'b0, pronto}, 32'd0);
      end else begin
        exp_b       = sb.pop_front();
        chk_pending = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Caller must be sitting on a negedge; frames can then be chained with no gap.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    entrada_serial = 1'b0;
    start_cyc      = cyc;
    idle(CLKS);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      idle(CLKS);
    end
    entrada_serial = stop_bit;
    idle(CLKS);
  endtask

  task automatic pulse_limpa();
    @(negedge clock) limpa = 1'b1;
    @(negedge clock) limpa = 1'b0;
  endtask

  task automatic wait_pronto(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dados"},   {24'b0, dados_ascii}, 32'd0);
    check_eq({tag, "_tem"},     {31'b0, tem_dado}, 32'd0);
    check_eq({tag, "_pronto"},  {31'b0, pronto}, 32'd0);
    check_eq({tag, "_framing"}, {31'b0, erro_framing}, 32'd0);
    check_eq({tag, "_overrun"}, {31'b0, erro_overrun}, 32'd0);
    check_eq({tag, "_estado"},  {28'b0, db_estado}, 32'd0);
    check_eq({tag, "_tick"},    {31'b0, db_tick}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    bit ok;

    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(5);
    check_eq("idle_state", {28'b0, db_estado}, 32'd1);

    // Single byte with latency measurement
    sb.push_back(8'h41);
    lat_armed = 1'b1;
    send_byte(8'h41, 1'b1);
    idle(20);
    check_eq("A_count", pronto_cnt, 32'd1);
    check_eq("A_tem", {31'b0, tem_dado}, 32'd1);
    check_eq("A_framing", {31'b0, erro_framing}, 32'd0);
    check_eq("A_overrun", {31'b0, erro_overrun}, 32'd0);
    pulse_limpa();
    check_eq("A_limpa_tem", {31'b0, tem_dado}, 32'd0);

    // Back-to-back frames, consumer draining after each pronto
    sb.push_back(8'h55);
    sb.push_back(8'hAA);
    fork
      begin
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_pronto(ok);
          check_eq("b2b_pronto_seen", {31'b0, ok}, 32'd1);
          idle(1);
          limpa = 1'b1;
          idle(1);
          limpa = 1'b0;
        end
      end
    join
    idle(20);
    check_eq("b2b_count", pronto_cnt, 32'd3);
    check_eq("b2b_overrun", {31'b0, erro_overrun}, 32'd0);
    check_eq("b2b_tem", {31'b0, tem_dado}, 32'd0);

    // 100-cycle glitch must be rejected at the half-bit sample
    saw_start = 1'b0;
    entrada_serial = 1'b0;
    idle(100);
    entrada_serial = 1'b1;
    idle(400);
    check_eq("glitch_saw_start", {31'b0, saw_start}, 32'd1);
    check_eq("glitch_state", {28'b0, db_estado}, 32'd1);
    check_eq("glitch_count", pronto_cnt, 32'd3);
    check_eq("glitch_tem", {31'b0, tem_dado}, 32'd0);
    check_eq("glitch_dados", {24'b0, dados_ascii}, 32'hAA);

    // Framing error: stop bit low, line held low afterwards
    send_byte(8'h3C, 1'b0);
    idle(200);
    check_eq("frm_state_erro", {28'b0, db_estado}, 32'd6);
    check_eq("frm_flag", {31'b0, erro_framing}, 32'd1);
    check_eq("frm_count", pronto_cnt, 32'd3);
    check_eq("frm_dados", {24'b0, dados_ascii}, 32'hAA);
    entrada_serial = 1'b1;
    idle(20);
    check_eq("frm_recover_state", {28'b0, db_estado}, 32'd1);
    check_eq("frm_sticky", {31'b0, erro_framing}, 32'd1);
    pulse_limpa();
    check_eq("frm_cleared", {31'b0, erro_framing}, 32'd0);

    // Overrun: two bytes without limpa
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(20);
    check_eq("ovr_count", pronto_cnt, 32'd5);
    check_eq("ovr_dados", {24'b0, dados_ascii}, 32'h34);
    check_eq("ovr_flag", {31'b0, erro_overrun}, 32'd1);
    check_eq("ovr_tem", {31'b0, tem_dado}, 32'd1);
    pulse_limpa();
    check_eq("ovr_limpa1_tem", {31'b0, tem_dado}, 32'd0);
    check_eq("ovr_limpa1_keeps_flag", {31'b0, erro_overrun}, 32'd1);
    pulse_limpa();
    check_eq("ovr_limpa2_clears", {31'b0, erro_overrun}, 32'd0);

    // Reset in the middle of bit 4 of 0x7E
    entrada_serial = 1'b0;
    idle(CLKS);
    for (int i = 0; i < 4; i++) begin
      entrada_serial = 1'(8'h7E >> i);
      idle(CLKS);
    end
    entrada_serial = 1'b1;
    idle(200);
    check_eq("mid_state_dados", {28'b0, db_estado}, 32'd3);
    #3 reset = 1'b1;
    @(negedge clock);
    check_all_zero("midreset");
    idle(10);
    reset = 1'b0;
    idle(50);
    sb.push_back(8'h21);
    send_byte(8'h21, 1'b1);
    idle(20);
    check_eq("post_reset_count", pronto_cnt, 32'd6);
    check_eq("post_reset_dados", {24'b0, dados_ascii}, 32'h21);
    check_eq("post_reset_framing", {31'b0, erro_framing}, 32'd0);
    check_eq("post_reset_overrun", {31'b0, erro_overrun}, 32'd0);
    check_eq("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the 8N1 stream our UART transmitter drives at 115200 baud from a 50 MHz clock.
- Recovers one byte per frame, holds it in a register until the consumer clears it, and flags framing and overrun errors.
- Sits at the board/host link input, and feeds received command bytes to the move-sequencing logic.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50M/115200); 5208 gives 9600 baud.
- CNT_W, 13, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- entrada_serial  in  1  asynchronous RX line; idles high.
- limpa  in  1  one-cycle pulse from consumer: byte taken, clears tem_dado.
- dados_ascii  out  8  last good byte received, LSB received first.
- tem_dado  out  1  holding register full.
- pronto  out  1  one-cycle pulse when a good byte is loaded.
- erro_framing  out  1  sticky; set when stop bit is sampled low.
- erro_overrun  out  1  sticky; set when a good byte arrives while tem_dado=1.
- db_estado  out  4  current FSM state code.
- db_tick  out  1  sample-point strobe, for debug.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- Reset values: all outputs 0; FSM in INICIAL; synchronizer flops 1 (line idle).
- Synchronizer: entrada_serial passes through 2 flops giving rx_s. All logic uses rx_s only.
- FSM states (db_estado code):
  - INICIAL (0): goes to ESPERA next cycle.
  - ESPERA (1): on rx_s=0, zero the counter and go to START.
  - START (2): count CLKS_PER_BIT/2 (217) cycles, then sample rx_s with db_tick=1.
    - If rx_s=1, the start was a glitch: return to ESPERA.
    - If rx_s=0, go to DADOS and clear the bit index.
  - DADOS (3): every CLKS_PER_BIT cycles, db_tick=1, sample rx_s into shift register bit [index]; bits arrive LSB first. After bit 7 is sampled, go to STOP.
  - STOP (4): after CLKS_PER_BIT cycles, sample rx_s.
    - If 1, go to ARMAZENA.
    - If 0, set erro_framing and go to ERRO.
  - ARMAZENA (5): one cycle.
    - Load dados_ascii from the shift register and set tem_dado=1.
    - Pulse pronto=1 for exactly this cycle.
    - If tem_dado was already 1 at entry, still overwrite the byte and set erro_overrun.
    - Next state: ESPERA.
  - ERRO (6): wait for rx_s=1, then go to ESPERA. The bad byte is discarded; dados_ascii and tem_dado are unchanged.
- Timing and latency:
  - Each sample is taken at the nominal bit centre.
  - pronto rises 2 + 217 + 9*434 + 1 = 4126 cycles (±2) after the falling edge of the start bit on entrada_serial.
- limpa:
  - Clears tem_dado on the next edge.
  - If limpa and the ARMAZENA load occur in the same cycle, the load wins: tem_dado=1 and no overrun is flagged for that byte.
- Sticky error flags: erro_framing and erro_overrun clear only on reset or on a limpa pulse issued while tem_dado=0.
- Back-to-back frames: a start bit is accepted in the first ESPERA cycle after ARMAZENA. No extra idle time is required.
- Reset mid-frame: returns immediately to INICIAL with all outputs 0, and no partial byte is kept.
- Counter: CNT_W-bit synchronous counter, zeroed on every state entry; it never wraps inside a bit.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state codes 0..6 (shared db_estado encoding with the TX control unit).
  - Baud constants 434 and 5208.
  - Frame constants: 8 data bits, 1 stop bit.
- Sub-module sincronizador_2ff: the 2-flop synchronizer, reset to 1.
- Counter, shift register and FSM stay in uart_rx.

Test Plan:
- Send 0x41 ('A') as 8N1 at 434 cycles/bit. Expect:
  - pronto pulses once, 4126±2 cycles after the start edge.
  - dados_ascii=0x41, tem_dado=1, both error flags 0.
- Send 0x55 then 0xAA back-to-back with no idle gap, pulsing limpa after each pronto. Expect:
  - two pronto pulses, reading 0x55 then 0xAA.
  - erro_overrun=0.
- Drive a 100-cycle low glitch on an idle line. Expect:
  - FSM goes ESPERA→START→ESPERA.
  - no pronto, and tem_dado and dados_ascii unchanged.
- Send 0x3C with the stop bit forced to 0. Expect:
  - erro_framing=1, no pronto, dados_ascii unchanged.
  - FSM held in ERRO (6) until the line goes high.
- Send 0x12, then 0x34 with no limpa in between. Expect:
  - dados_ascii=0x34, erro_overrun=1, tem_dado=1.
  - a later limpa with tem_dado=0 clears erro_overrun.
- Assert reset during bit 4 of 0x7E, then send 0x21. Expect:
  - all outputs 0 while reset is held.
  - the next frame is received correctly as 0x21.
